// File: rtl/gpu_display_fetch_sched.sv
// VRAM burst scheduler: display line fetch has priority over draw-engine bursts.
// Latency: grant registers into REQ next cycle; one burst per >=3 cycles (IDLE->REQ->WAIT).
// Backpressure: REQ holds until i_memAck, WAIT until i_memDone; display waits on i_fifoRoom.
module gpu_display_fetch_sched #(
  parameter int ADDR_W  = 17,
  parameter int BURST_W = 3
) (
  input  logic              i_gpuPixClk,
  input  logic              i_rst,
  input  logic              i_hbl,
  input  logic              i_vbl,
  input  logic [ADDR_W-1:0] i_dispBaseAddr,
  input  logic [ADDR_W-1:0] i_lineStride,
  input  logic [6:0]        i_burstsPerLine,
  input  logic              i_fifoRoom,
  input  logic              i_drawReq,
  input  logic [ADDR_W-1:0] i_drawAddr,
  input  logic              i_drawWrite,
  output logic              o_drawAck,
  output logic              o_memReq,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic              o_memWrite,
  output logic              o_memToDisplay,
  input  logic              i_memAck,
  input  logic              i_memDone,
  input  logic              i_clrStatus,
  output logic              o_underflow
);

  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(2 ** BURST_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              hbl_prev_q, vbl_prev_q;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [6:0]        pending_q, pending_d;
  logic              own_disp_q, own_disp_d;
  logic              mem_write_q, mem_write_d;
  logic              underflow_q, underflow_d;

  logic              hbl_rise, vbl_rise, hbl_fall, line_load;
  logic              burst_done, disp_done, draw_done;
  logic              grant_disp, busy;
  logic [6:0]        pending_eff;
  logic              pend_left;

  // Blanking edges relative to the previous cycle's sample.
  assign hbl_rise  = i_hbl & ~hbl_prev_q;
  assign vbl_rise  = i_vbl & ~vbl_prev_q;
  assign hbl_fall  = ~i_hbl & hbl_prev_q;
  // A line reload needs vertical blank low; this also lets vblRise win a tie.
  assign line_load = hbl_rise & ~i_vbl;

  // Completion is credited to whoever owned the burst when it was granted.
  assign burst_done = (state_q == S_WAIT) & i_memDone;
  assign disp_done  = burst_done & own_disp_q;
  assign draw_done  = burst_done & ~own_disp_q;

  // A burst finishing this very cycle no longer counts as outstanding work
  // when judging whether the line ran late.
  assign pending_eff = (disp_done && (pending_q != 7'd0)) ? (pending_q - 7'd1) : pending_q;
  assign pend_left   = (pending_eff != 7'd0);

  assign grant_disp = (pending_q != 7'd0) & i_fifoRoom;
  assign busy       = (state_q != S_IDLE);

  // Line/fetch address, burst count and sticky underflow next-state.
  always_comb begin
    line_addr_d  = line_addr_q;
    fetch_addr_d = fetch_addr_q;
    pending_d    = pending_q;
    underflow_d  = underflow_q;

    if (disp_done && (pending_q != 7'd0)) begin
      pending_d    = pending_q - 7'd1;
      fetch_addr_d = fetch_addr_q + BURST_STEP;
    end

    if (vbl_rise) begin
      line_addr_d = i_dispBaseAddr;
      pending_d   = 7'd0;
    end else if (line_load) begin
      // Any burst still in flight from the old line decrements this new count.
      pending_d    = i_burstsPerLine;
      fetch_addr_d = line_addr_q;
      line_addr_d  = line_addr_q + i_lineStride;
    end

    if (i_clrStatus) begin
      underflow_d = 1'b0;
    end
    if ((line_load || hbl_fall) && pend_left) begin
      underflow_d = 1'b1;
    end
  end

  // Arbiter FSM next-state: latch owner/address/direction on grant, then hold.
  always_comb begin
    state_d     = state_q;
    own_disp_d  = own_disp_q;
    mem_addr_d  = mem_addr_q;
    mem_write_d = mem_write_q;

    case (state_q)
      S_IDLE: begin
        if (grant_disp) begin
          own_disp_d  = 1'b1;
          mem_addr_d  = fetch_addr_q;
          mem_write_d = 1'b0;
          state_d     = S_REQ;
        end else if (i_drawReq) begin
          own_disp_d  = 1'b0;
          mem_addr_d  = i_drawAddr;
          mem_write_d = i_drawWrite;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (i_memAck) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_memDone) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Blanking history and display counters.
  always_ff @(posedge i_gpuPixClk or posedge i_rst) begin
    if (i_rst) begin
      hbl_prev_q   <= 1'b0;
      vbl_prev_q   <= 1'b0;
      line_addr_q  <= '0;
      fetch_addr_q <= '0;
      pending_q    <= 7'd0;
      underflow_q  <= 1'b0;
    end else begin
      hbl_prev_q   <= i_hbl;
      vbl_prev_q   <= i_vbl;
      line_addr_q  <= line_addr_d;
      fetch_addr_q <= fetch_addr_d;
      pending_q    <= pending_d;
      underflow_q  <= underflow_d;
    end
  end

  // Arbiter state and the latched burst descriptor; reset drops any burst in flight.
  always_ff @(posedge i_gpuPixClk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      own_disp_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_disp_q  <= own_disp_d;
      mem_addr_q  <= mem_addr_d;
      mem_write_q <= mem_write_d;
    end
  end

  // Direction/routing only mean something while a burst is outstanding.
  assign o_memReq       = (state_q == S_REQ);
  assign o_memAddr      = mem_addr_q;
  assign o_memWrite     = mem_write_q & busy;
  assign o_memToDisplay = own_disp_q & busy;
  // Same-cycle ack lets the draw engine drop its request before the FSM is back in IDLE.
  assign o_drawAck      = draw_done;
  assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_gpu_display_fetch_sched.sv
`timescale 1ns/1ps
module tb_gpu_display_fetch_sched;
  localparam int ADDR_W  = 17;
  localparam int BURST_W = 3;
  localparam int STEP    = 1 << BURST_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              hbl, vbl;
  logic [ADDR_W-1:0] base, stride;
  logic [6:0]        bpl;
  logic              fifo_room;
  logic              draw_req;
  logic [ADDR_W-1:0] draw_addr;
  logic              draw_write;
  logic              draw_ack;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write, mem_to_disp;
  logic              mem_ack, mem_done;
  logic              clr_status;
  logic              underflow;

  always #5 clk = ~clk;

  gpu_display_fetch_sched #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) dut (
    .i_gpuPixClk    (clk),
    .i_rst          (rst),
    .i_hbl          (hbl),
    .i_vbl          (vbl),
    .i_dispBaseAddr (base),
    .i_lineStride   (stride),
    .i_burstsPerLine(bpl),
    .i_fifoRoom     (fifo_room),
    .i_drawReq      (draw_req),
    .i_drawAddr     (draw_addr),
    .i_drawWrite    (draw_write),
    .o_drawAck      (draw_ack),
    .o_memReq       (mem_req),
    .o_memAddr      (mem_addr),
    .o_memWrite     (mem_write),
    .o_memToDisplay (mem_to_disp),
    .i_memAck       (mem_ack),
    .i_memDone      (mem_done),
    .i_clrStatus    (clr_status),
    .o_underflow    (underflow)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
  } burst_t;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected display bursts in line order, expected draw bursts in issue order.
  burst_t disp_q[$];
  burst_t draw_q[$];
  int disp_acc = 0, draw_acc = 0, ack_cnt = 0, draws_issued = 0;
  int draw_disp_left = -1;

  // Reference model of the display raster: line n of a frame starts at base + n*stride.
  logic [ADDR_W-1:0] m_base = '0, m_stride = '0;
  int m_line = 0;

  // Memory responder knobs.
  int ack_max = 0, done_min = 4, done_max = 4;
  bit hold_done = 0;
  int rs = 0, rcnt = 0;
  bit rand_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vbl_pulse();
    tick();
    vbl = 1'b1;
    m_line = 0; m_base = base; m_stride = stride;
    repeat (3) tick();
    vbl = 1'b0;
  endtask

  task automatic line_start();
    burst_t b;
    tick();
    hbl = 1'b1;
    if (!vbl) begin
      for (int k = 0; k < int'(bpl); k++) begin
        b.addr = m_base + ADDR_W'(m_line) * m_stride + ADDR_W'(k * STEP);
        b.wr   = 1'b0;
        disp_q.push_back(b);
      end
      m_line++;
    end
  endtask

  task automatic line_end();
    tick();
    hbl = 1'b0;
  endtask

  task automatic do_draw(input logic [ADDR_W-1:0] a, input logic w, input int budget);
    burst_t b;
    int n;
    bit got;
    tick();
    draw_req = 1'b1; draw_addr = a; draw_write = w;
    b.addr = a; b.wr = w;
    draw_q.push_back(b);
    draws_issued++;
    n = 0; got = 0;
    while (!got && n < budget) begin
      @(negedge clk);
      if (draw_ack) got = 1;
      n++;
    end
    chk("draw_complete", 32'(got), 32'd1);
    tick();
    draw_req = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((disp_q.size() != 0 || draw_q.size() != 0 || mem_req) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
    repeat (12) @(negedge clk);
  endtask

  // Memory controller model: ack after 0..ack_max cycles, done done_min..done_max later.
  initial begin : responder
    mem_ack = 1'b0; mem_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0; mem_done = 1'b0;
      if (rst) begin
        rs = 0;
      end else begin
        case (rs)
          0: if (mem_req) begin
               rcnt = int'($urandom_range(ack_max, 0));
               if (rcnt == 0) begin
                 mem_ack = 1'b1; rcnt = int'($urandom_range(done_max, done_min)); rs = 2;
               end else rs = 1;
             end
          1: begin
               rcnt--;
               if (rcnt == 0) begin
                 mem_ack = 1'b1; rcnt = int'($urandom_range(done_max, done_min)); rs = 2;
               end
             end
          default: if (!hold_done) begin
               if (rcnt <= 1) begin mem_done = 1'b1; rs = 0; end
               else rcnt--;
             end
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted request, checks request stability and ack shape.
  initial begin : monitor
    burst_t exp_b;
    logic prev_req, prev_acc, prev_ack;
    logic [31:0] prev_sig;
    prev_req = 0; prev_acc = 0; prev_ack = 0; prev_sig = '0;
    forever begin
      @(negedge clk);
      if (!rst && prev_req && !prev_acc)
        chk("req_stable", {13'd0, mem_req, mem_addr, mem_write, mem_to_disp}, {13'd0, 1'b1, prev_sig[18:0]});
      if (!rst && prev_req && prev_acc)
        chk("req_drop_after_ack", 32'(mem_req), 32'd0);
      if (!rst && mem_req && mem_ack) begin
        checks++;
        if (mem_to_disp) begin
          if (disp_q.size() == 0) begin
            errors++;
            $display("FAIL disp_unexpected addr=%0h expected no display burst", mem_addr);
          end else begin
            exp_b = disp_q.pop_front();
            if (mem_addr !== exp_b.addr || mem_write !== 1'b0) begin
              errors++;
              $display("FAIL disp_burst addr=%0h wr=%0b expected addr=%0h wr=0", mem_addr, mem_write, exp_b.addr);
            end
            disp_acc++;
          end
        end else begin
          if (draw_q.size() == 0) begin
            errors++;
            $display("FAIL draw_unexpected addr=%0h expected no draw burst", mem_addr);
          end else begin
            exp_b = draw_q.pop_front();
            if (mem_addr !== exp_b.addr || mem_write !== exp_b.wr) begin
              errors++;
              $display("FAIL draw_burst addr=%0h wr=%0b expected addr=%0h wr=%0b", mem_addr, mem_write, exp_b.addr, exp_b.wr);
            end
            draw_acc++;
            draw_disp_left = disp_q.size();
          end
        end
      end
      if (draw_ack) begin
        chk("drawack_single_pulse", 32'(prev_ack), 32'd0);
        chk("drawack_has_owner", 32'(draw_acc > ack_cnt), 32'd1);
        ack_cnt++;
      end
      prev_ack = draw_ack;
      prev_req = mem_req & ~rst;
      prev_acc = mem_ack;
      prev_sig = {13'd0, 1'b1, mem_addr, mem_write, mem_to_disp};
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int acc0, ack0;
    rst = 1'b1; hbl = 0; vbl = 0; base = '0; stride = '0; bpl = '0; fifo_room = 1'b1;
    draw_req = 0; draw_addr = '0; draw_write = 0; clr_status = 0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_memReq", 32'(mem_req), 0);
    chk("rst_memAddr", 32'(mem_addr), 0);
    chk("rst_memWrite", 32'(mem_write), 0);
    chk("rst_memToDisplay", 32'(mem_to_disp), 0);
    chk("rst_drawAck", 32'(draw_ack), 0);
    chk("rst_underflow", 32'(underflow), 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Basic line fetch: 0x100/0x108/0x110, next line at 0x180.
    base = 17'h100; stride = 17'h80; bpl = 7'd3;
    ack_max = 0; done_min = 4; done_max = 4;
    vbl_pulse();
    repeat (3) tick();
    line_start();
    wait_drain("t1_line0_drain", 200);
    line_end();
    repeat (5) tick();
    line_start();
    wait_drain("t1_line1_drain", 200);
    line_end();
    chk("t1_disp_count", 32'(disp_acc), 32'd6);
    repeat (5) tick();

    // Display has priority over a held draw request.
    line_start();
    do_draw(17'h1ABCD, 1'b1, 300);
    chk("t2_draw_after_display", 32'(draw_disp_left), 32'd0);
    wait_drain("t2_drain", 200);
    line_end();
    repeat (5) tick();

    // No FIFO room: draw proceeds, display resumes when room returns.
    fifo_room = 1'b0; bpl = 7'd2;
    acc0 = disp_acc;
    line_start();
    do_draw(17'h0F0F0, 1'b0, 200);
    chk("t3_no_display_without_room", 32'(disp_acc), 32'(acc0));
    fifo_room = 1'b1;
    wait_drain("t3_resume_drain", 200);
    chk("t3_display_resumed", 32'(disp_acc), 32'(acc0 + 2));
    line_end();
    repeat (5) tick();

    // Late line: underflow on hblank fall, sticky, cleared by clrStatus.
    hold_done = 1;
    line_start();
    repeat (10) tick();
    line_end();
    repeat (2) tick();
    @(negedge clk);
    chk("t4_underflow_set", 32'(underflow), 32'd1);
    repeat (5) @(negedge clk);
    chk("t4_underflow_held", 32'(underflow), 32'd1);
    hold_done = 0;
    wait_drain("t4_drain", 200);
    chk("t4_underflow_sticky", 32'(underflow), 32'd1);
    tick();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    @(negedge clk);
    chk("t4_underflow_cleared", 32'(underflow), 32'd0);

    // Reset while a draw write burst sits in WAIT.
    hold_done = 1;
    tick();
    draw_req = 1'b1; draw_addr = 17'h15555; draw_write = 1'b1;
    begin
      burst_t b;
      int n;
      b.addr = 17'h15555; b.wr = 1'b1;
      draw_q.push_back(b);
      acc0 = draw_acc;
      n = 0;
      while (draw_acc == acc0 && n < 30) begin @(negedge clk); n++; end
      chk("t5_draw_accepted", 32'(draw_acc), 32'(acc0 + 1));
    end
    repeat (2) @(negedge clk);
    chk("t5_in_wait_write", 32'(mem_write), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_memReq", 32'(mem_req), 0);
    chk("t5_rst_memAddr", 32'(mem_addr), 0);
    chk("t5_rst_memWrite", 32'(mem_write), 0);
    chk("t5_rst_memToDisplay", 32'(mem_to_disp), 0);
    chk("t5_rst_drawAck", 32'(draw_ack), 0);
    draw_req = 1'b0; hold_done = 0;
    ack0 = ack_cnt;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("t5_no_ack_after_reset", 32'(ack_cnt), 32'(ack0));

    // vblRise and hblRise together: no fetch, next line starts at base.
    base = 17'h300; stride = 17'h40; bpl = 7'd3;
    tick();
    vbl = 1'b1; hbl = 1'b1;
    m_line = 0; m_base = base; m_stride = stride;
    acc0 = disp_acc;
    repeat (30) tick();
    chk("t6_no_fetch", 32'(disp_acc), 32'(acc0));
    vbl = 1'b0;
    repeat (3) tick();
    hbl = 1'b0;
    repeat (5) tick();
    line_start();
    wait_drain("t6_drain", 200);
    line_end();
    chk("t6_fetch_from_base", 32'(disp_acc), 32'(acc0 + 3));
    repeat (5) tick();

    // Randomized frames with background draw traffic and FIFO room toggling.
    ack_max = 2; done_min = 1; done_max = 5;
    ack0 = ack_cnt;
    acc0 = draws_issued;
    rand_run = 1;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          base = ADDR_W'($urandom); stride = ADDR_W'($urandom); bpl = 7'($urandom_range(4, 0));
          vbl_pulse();
          repeat (5) tick();
          for (int l = 0; l < 5; l++) begin
            line_start();
            repeat (150) tick();
            line_end();
            repeat (20) tick();
          end
        end
        rand_run = 0;
      end
      begin
        while (rand_run) begin
          repeat ($urandom_range(60, 5)) tick();
          if (rand_run) do_draw(ADDR_W'($urandom), 1'($urandom), 400);
        end
      end
      begin
        while (rand_run) begin
          tick();
          fifo_room = ($urandom_range(3, 0) != 0);
        end
        fifo_room = 1'b1;
      end
    join
    wait_drain("rand_drain", 400);
    chk("rand_no_underflow", 32'(underflow), 32'd0);
    chk("rand_all_draws_acked", 32'(ack_cnt - ack0), 32'(draws_issued - acc0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
